ram_dp_be_clr: RTL and testbench

- Parametrised single-clock true dual-port RAM for shared video/sprite/work memories; successor of the two-write-port block RAM.
- Adds byte-lane write enables, selectable read-during-write mode, deterministic cross-port write arbitration with a collision flag, and a hardware clear engine that sweeps all locations to a fixed value after reset or on request.

---
 rtl/ram_dp_be_clr.sv | 123 ++++++++++++
 tb/tb_ram_dp_be_clr.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/ram_dp_be_clr.sv
// True dual-port single-clock RAM with byte-lane writes, selectable read-during-write,
// port-A-priority write arbitration with a collision flag, and a sweep-style clear engine.
module ram_dp_be_clr #(
  parameter int                    ADDR_WIDTH     = 11,
  parameter int                    DATA_WIDTH     = 8,
  parameter int                    LANES          = DATA_WIDTH / 8,
  parameter int                    RDW_MODE       = 0,
  parameter logic [DATA_WIDTH-1:0] CLEAR_VALUE    = '0,
  parameter bit                    CLEAR_ON_RESET = 1'b1
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic                  clear_req,
  output logic                  busy,
  output logic                  collision,
  input  logic                  enable_a,
  input  logic                  enable_b,
  input  logic                  wren_a,
  input  logic                  wren_b,
  input  logic [LANES-1:0]      be_a,
  input  logic [LANES-1:0]      be_b,
  input  logic [ADDR_WIDTH-1:0] address_a,
  input  logic [ADDR_WIDTH-1:0] address_b,
  input  logic [DATA_WIDTH-1:0] data_a,
  input  logic [DATA_WIDTH-1:0] data_b,
  output logic [DATA_WIDTH-1:0] q_a,
  output logic [DATA_WIDTH-1:0] q_b
);

  localparam int                    DEPTH   = 2 ** ADDR_WIDTH;
  localparam logic [ADDR_WIDTH-1:0] CNT_ONE = 1;
  localparam logic [ADDR_WIDTH-1:0] CNT_MAX = '1;

  typedef enum logic {ST_IDLE, ST_CLEAR} state_t;

  state_t                  state, state_nxt;
  logic [ADDR_WIDTH-1:0]   cnt;
  logic [DATA_WIDTH-1:0]   mem [DEPTH];

  logic                    idle_p0;
  logic                    same_p0;
  logic [LANES-1:0]        lane_a_p0;
  logic [LANES-1:0]        lane_b_raw_p0;
  logic [LANES-1:0]        lane_b_p0;
  logic [DATA_WIDTH-1:0]   old_a_p0, old_b_p0;
  logic [DATA_WIDTH-1:0]   word_a_p0, word_b_p0;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state <= CLEAR_ON_RESET ? ST_CLEAR : ST_IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      if (state == ST_CLEAR)
        cnt <= cnt + CNT_ONE;
    end
  end

  always_comb begin
    state_nxt = state;
    busy      = 1'b0;
    case (state)
      ST_IDLE:  if (clear_req) state_nxt = ST_CLEAR;
      ST_CLEAR: begin
        busy = 1'b1;
        if (cnt == CNT_MAX) state_nxt = ST_IDLE;
      end
      default:  state_nxt = ST_IDLE;
    endcase
  end

  // Stage p0: lane arbitration and merged write words; A owns any lane it enables
  always_comb begin
    idle_p0   = (state == ST_IDLE);
    same_p0   = (address_a == address_b);
    old_a_p0  = mem[address_a];
    old_b_p0  = mem[address_b];
    lane_a_p0     = '0;
    lane_b_raw_p0 = '0;
    lane_b_p0     = '0;
    word_a_p0     = old_a_p0;
    word_b_p0     = old_b_p0;
    for (int i = 0; i < LANES; i++) begin
      lane_a_p0[i]     = idle_p0 & enable_a & wren_a & be_a[i];
      lane_b_raw_p0[i] = idle_p0 & enable_b & wren_b & be_b[i];
      lane_b_p0[i]     = lane_b_raw_p0[i] & ~(same_p0 & lane_a_p0[i]);
      if (lane_a_p0[i])
        word_a_p0[8*i +: 8] = data_a[8*i +: 8];
      else if (same_p0 && lane_b_p0[i])
        word_a_p0[8*i +: 8] = data_b[8*i +: 8];
      if (same_p0 && lane_a_p0[i])
        word_b_p0[8*i +: 8] = data_a[8*i +: 8];
      else if (lane_b_p0[i])
        word_b_p0[8*i +: 8] = data_b[8*i +: 8];
    end
  end

  // Stage p1: storage; on a shared address both merged words are identical
  always_ff @(posedge clock) begin
    if (state == ST_CLEAR) begin
      mem[cnt] <= CLEAR_VALUE;
    end else begin
      if (|lane_b_p0) mem[address_b] <= word_b_p0;
      if (|lane_a_p0) mem[address_a] <= word_a_p0;
    end
  end

  // Stage p1: registered read ports; a reader never sees the other port's write
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      q_a       <= '0;
      q_b       <= '0;
      collision <= 1'b0;
    end else begin
      if (idle_p0 && enable_a)
        q_a <= ((|lane_a_p0) && RDW_MODE == 0) ? word_a_p0 : old_a_p0;
      if (idle_p0 && enable_b)
        q_b <= ((|lane_b_raw_p0) && RDW_MODE == 0) ? word_b_p0 : old_b_p0;
      collision <= same_p0 & (|lane_a_p0) & (|lane_b_raw_p0);
    end
  end

endmodule

// File: tb/tb_ram_dp_be_clr.sv
// Scoreboard bench: two instances (post-write and pre-write read modes) share stimulus;
// expected responses are queued at issue time and checked by a negedge monitor.
module tb_ram_dp_be_clr;

  localparam logic [15:0] CV    = 16'hC3E1;
  localparam int          DEPTH = 16;

  logic        clock = 1'b0;
  logic        reset_n;
  logic        clear_req;
  logic        en_a, en_b, wr_a, wr_b;
  logic [1:0]  be_a, be_b;
  logic [3:0]  ad_a, ad_b;
  logic [15:0] d_a, d_b;
  logic        busy0, busy1, coll0, coll1;
  logic [15:0] q_a0, q_b0, q_a1, q_b1;

  int tests = 0;
  int fails = 0;
  int cyc   = 0;
  int run   = 0;
  int runs  = 0;

  typedef struct {
    string       nm;
    int          due;
    bit          ca, cb;
    logic [15:0] a0, a1, b0, b1;
    logic        bsy, col;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;

  ram_dp_be_clr #(.ADDR_WIDTH(4), .DATA_WIDTH(16), .RDW_MODE(0),
                  .CLEAR_VALUE(CV), .CLEAR_ON_RESET(1'b1)) dut0 (
    .clock(clock), .reset_n(reset_n), .clear_req(clear_req), .busy(busy0), .collision(coll0),
    .enable_a(en_a), .enable_b(en_b), .wren_a(wr_a), .wren_b(wr_b), .be_a(be_a), .be_b(be_b),
    .address_a(ad_a), .address_b(ad_b), .data_a(d_a), .data_b(d_b), .q_a(q_a0), .q_b(q_b0));

  ram_dp_be_clr #(.ADDR_WIDTH(4), .DATA_WIDTH(16), .RDW_MODE(1),
                  .CLEAR_VALUE(CV), .CLEAR_ON_RESET(1'b1)) dut1 (
    .clock(clock), .reset_n(reset_n), .clear_req(clear_req), .busy(busy1), .collision(coll1),
    .enable_a(en_a), .enable_b(en_b), .wren_a(wr_a), .wren_b(wr_b), .be_a(be_a), .be_b(be_b),
    .address_a(ad_a), .address_b(ad_b), .data_a(d_a), .data_b(d_b), .q_a(q_a1), .q_b(q_b1));

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got %h, required %h", nm, act, req);
    end
  endtask

  // Monitor: busy-run length plus queued per-cycle expectations
  always @(negedge clock) begin
    if (!reset_n) run = 0;
    else if (busy0) run++;
    else if (run != 0) begin
      chk("busy_len", 16'(run), 16'(DEPTH));
      runs++;
      run = 0;
    end
    while (sb.size() > 0 && sb[0].due <= cyc) begin
      mon_e = sb.pop_front();
      if (mon_e.ca) begin
        chk({mon_e.nm, "/q_a rdw0"}, q_a0, mon_e.a0);
        chk({mon_e.nm, "/q_a rdw1"}, q_a1, mon_e.a1);
      end
      if (mon_e.cb) begin
        chk({mon_e.nm, "/q_b rdw0"}, q_b0, mon_e.b0);
        chk({mon_e.nm, "/q_b rdw1"}, q_b1, mon_e.b1);
      end
      chk({mon_e.nm, "/busy0"}, {15'd0, busy0}, {15'd0, mon_e.bsy});
      chk({mon_e.nm, "/busy1"}, {15'd0, busy1}, {15'd0, mon_e.bsy});
      chk({mon_e.nm, "/coll0"}, {15'd0, coll0}, {15'd0, mon_e.col});
      chk({mon_e.nm, "/coll1"}, {15'd0, coll1}, {15'd0, mon_e.col});
    end
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic port_a(input logic en, input logic wr, input logic [1:0] be,
                        input logic [3:0] ad, input logic [15:0] d);
    en_a = en; wr_a = wr; be_a = be; ad_a = ad; d_a = d;
  endtask

  task automatic port_b(input logic en, input logic wr, input logic [1:0] be,
                        input logic [3:0] ad, input logic [15:0] d);
    en_b = en; wr_b = wr; be_b = be; ad_b = ad; d_b = d;
  endtask

  task automatic ports_idle();
    port_a(1'b0, 1'b0, 2'b00, 4'd0, 16'h0000);
    port_b(1'b0, 1'b0, 2'b00, 4'd0, 16'h0000);
  endtask

  task automatic expq(input string nm, input int dly,
                      input bit ca, input logic [15:0] a0, input logic [15:0] a1,
                      input bit cb, input logic [15:0] b0, input logic [15:0] b1,
                      input logic bsy, input logic col);
    exp_t x;
    x.nm = nm; x.due = cyc + dly; x.ca = ca; x.cb = cb;
    x.a0 = a0; x.a1 = a1; x.b0 = b0; x.b1 = b1; x.bsy = bsy; x.col = col;
    sb.push_back(x);
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 64 && busy0; i++) tick();
    tests++;
    if (busy0) begin
      fails++;
      $display("FAIL wait_idle: busy %0d after 64 cycles, required 0", busy0);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset_n = 1'b0; clear_req = 1'b0;
    ports_idle();
    repeat (2) tick();
    expq("reset", 0, 1, 16'h0, 16'h0, 1, 16'h0, 16'h0, 1'b1, 1'b0);
    tick();
    reset_n = 1'b1;

    // Power-on sweep; a dual write on sweep cycle 5 must be dropped
    repeat (4) tick();
    port_a(1'b1, 1'b1, 2'b11, 4'd2, 16'h1111);
    port_b(1'b1, 1'b1, 2'b11, 4'd2, 16'h2222);
    expq("sweep_wr", 1, 1, 16'h0, 16'h0, 1, 16'h0, 16'h0, 1'b1, 1'b0);
    tick();
    ports_idle();
    wait_idle();

    for (int i = 0; i < DEPTH; i++) begin
      port_a(1'b1, 1'b0, 2'b00, 4'(i), 16'h0);
      port_b(1'b1, 1'b0, 2'b00, 4'(DEPTH - 1 - i), 16'h0);
      expq("cleared", 1, 1, CV, CV, 1, CV, CV, 1'b0, 1'b0);
      tick();
    end
    ports_idle();

    // Byte lanes
    port_a(1'b1, 1'b1, 2'b11, 4'd3, 16'hA5A5);
    expq("be_full", 1, 1, 16'hA5A5, CV, 0, 16'h0, 16'h0, 1'b0, 1'b0);
    tick();
    port_a(1'b1, 1'b1, 2'b10, 4'd3, 16'h1234);
    expq("be_hi", 1, 1, 16'h12A5, 16'hA5A5, 0, 16'h0, 16'h0, 1'b0, 1'b0);
    tick();
    port_a(1'b0, 1'b0, 2'b00, 4'd0, 16'h0);
    port_b(1'b1, 1'b0, 2'b00, 4'd3, 16'h0);
    expq("be_rd", 1, 0, 16'h0, 16'h0, 1, 16'h12A5, 16'h12A5, 1'b0, 1'b0);
    tick();

    // Read-during-write, same port and cross port
    port_a(1'b1, 1'b1, 2'b11, 4'd7, 16'h0011);
    port_b(1'b0, 1'b0, 2'b00, 4'd0, 16'h0);
    expq("rdw_init", 1, 1, 16'h0011, CV, 0, 16'h0, 16'h0, 1'b0, 1'b0);
    tick();
    port_a(1'b1, 1'b1, 2'b11, 4'd7, 16'h0022);
    port_b(1'b1, 1'b0, 2'b00, 4'd7, 16'h0);
    expq("rdw", 1, 1, 16'h0022, 16'h0011, 1, 16'h0011, 16'h0011, 1'b0, 1'b0);
    tick();
    port_a(1'b0, 1'b1, 2'b11, 4'd7, 16'hFFFF);
    port_b(1'b1, 1'b1, 2'b00, 4'd7, 16'h9999);
    expq("en0_be0", 1, 1, 16'h0022, 16'h0011, 1, 16'h0022, 16'h0022, 1'b0, 1'b0);
    tick();
    port_a(1'b1, 1'b0, 2'b00, 4'd7, 16'h0);
    port_b(1'b0, 1'b0, 2'b00, 4'd0, 16'h0);
    expq("en0_be0_rd", 1, 1, 16'h0022, 16'h0022, 0, 16'h0, 16'h0, 1'b0, 1'b0);
    tick();

    // Collision and independent dual write
    port_a(1'b1, 1'b1, 2'b01, 4'd9, 16'hAAAA);
    port_b(1'b1, 1'b1, 2'b11, 4'd9, 16'hBBBB);
    expq("coll", 1, 1, 16'hBBAA, CV, 1, 16'hBBAA, CV, 1'b0, 1'b1);
    tick();
    port_a(1'b1, 1'b0, 2'b00, 4'd9, 16'h0);
    port_b(1'b0, 1'b0, 2'b00, 4'd0, 16'h0);
    expq("coll_rd", 1, 1, 16'hBBAA, 16'hBBAA, 0, 16'h0, 16'h0, 1'b0, 1'b0);
    tick();
    port_a(1'b1, 1'b1, 2'b11, 4'd10, 16'h1111);
    port_b(1'b1, 1'b1, 2'b11, 4'd11, 16'h2222);
    expq("diff_wr", 1, 1, 16'h1111, CV, 1, 16'h2222, CV, 1'b0, 1'b0);
    tick();
    port_a(1'b1, 1'b0, 2'b00, 4'd11, 16'h0);
    port_b(1'b1, 1'b0, 2'b00, 4'd10, 16'h0);
    expq("diff_rd", 1, 1, 16'h2222, 16'h2222, 1, 16'h1111, 16'h1111, 1'b0, 1'b0);
    tick();

    // Edge addresses, then a requested clear with a re-pulse mid-sweep
    port_a(1'b1, 1'b1, 2'b11, 4'd0, 16'hDEAD);
    port_b(1'b1, 1'b1, 2'b11, 4'd15, 16'hBEEF);
    expq("edge_wr", 1, 1, 16'hDEAD, CV, 1, 16'hBEEF, CV, 1'b0, 1'b0);
    tick();
    port_a(1'b1, 1'b0, 2'b00, 4'd15, 16'h0);
    port_b(1'b1, 1'b0, 2'b00, 4'd0, 16'h0);
    expq("edge_rd", 1, 1, 16'hBEEF, 16'hBEEF, 1, 16'hDEAD, 16'hDEAD, 1'b0, 1'b0);
    tick();
    ports_idle();
    clear_req = 1'b1;
    expq("clr_start", 1, 1, 16'hBEEF, 16'hBEEF, 1, 16'hDEAD, 16'hDEAD, 1'b1, 1'b0);
    tick();
    for (int k = 0; k < 14; k++) begin
      clear_req = (k == 2);
      port_a(1'b1, 1'b1, 2'b11, 4'd15, 16'h6666);
      port_b(1'b1, 1'b1, 2'b11, 4'd15, 16'h7777);
      expq("clr_hold", 1, 1, 16'hBEEF, 16'hBEEF, 1, 16'hDEAD, 16'hDEAD, 1'b1, 1'b0);
      tick();
    end
    clear_req = 1'b0;
    ports_idle();
    wait_idle();
    port_a(1'b1, 1'b0, 2'b00, 4'd0, 16'h0);
    port_b(1'b1, 1'b0, 2'b00, 4'd15, 16'h0);
    expq("clr_edges", 1, 1, CV, CV, 1, CV, CV, 1'b0, 1'b0);
    tick();
    port_a(1'b1, 1'b0, 2'b00, 4'd3, 16'h0);
    port_b(1'b1, 1'b0, 2'b00, 4'd9, 16'h0);
    expq("clr_mid", 1, 1, CV, CV, 1, CV, CV, 1'b0, 1'b0);
    tick();
    port_a(1'b1, 1'b1, 2'b11, 4'd12, 16'h4321);
    port_b(1'b0, 1'b0, 2'b00, 4'd0, 16'h0);
    expq("pre_rst_wr", 1, 1, 16'h4321, CV, 0, 16'h0, 16'h0, 1'b0, 1'b0);
    tick();

    // Reset mid-sweep restarts a full sweep
    ports_idle();
    clear_req = 1'b1;
    expq("clr2", 1, 1, 16'h4321, CV, 1, CV, CV, 1'b1, 1'b0);
    tick();
    clear_req = 1'b0;
    repeat (6) tick();
    reset_n = 1'b0;
    expq("rst_mid", 0, 1, 16'h0, 16'h0, 1, 16'h0, 16'h0, 1'b1, 1'b0);
    tick();
    tick();
    expq("rst_hold", 0, 1, 16'h0, 16'h0, 1, 16'h0, 16'h0, 1'b1, 1'b0);
    reset_n = 1'b1;
    wait_idle();
    expq("post_rst", 0, 1, 16'h0, 16'h0, 1, 16'h0, 16'h0, 1'b0, 1'b0);
    port_a(1'b1, 1'b0, 2'b00, 4'd12, 16'h0);
    port_b(1'b1, 1'b0, 2'b00, 4'd3, 16'h0);
    expq("restart_clr", 1, 1, CV, CV, 1, CV, CV, 1'b0, 1'b0);
    tick();
    ports_idle();
    repeat (2) tick();

    chk("sb_drained", 16'(sb.size()), 16'd0);
    chk("busy_runs", 16'(runs), 16'd3);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
